level_sequencer: RTL
====================

# level_sequencer

Session-level controller that sequences `game_controller` through successive rounds. It drives `start`, `initial_time` and `button_count`, and watches the round outcome on `state`/`time_remaining`. It keeps level, lives and score for a multi-round game, and it sits between the player's start button and `game_controller` in the top level.

## Interface
Parameters:
- `BASE_TIME`, 600: level-0 round time, in `game_controller` ticks.
- `TIME_STEP`, 40: time removed per level.
- `MIN_TIME`, 200: floor on round time.
- `BASE_BUTTONS`, 4: level-0 sequence length.
- `MAX_LIVES`, 3: lives at new game (1..3).
- `START_HOLD`, 4: cycles `gc_start` is held high, and then held low, per pulse (≥4).

Ports:
- `clk`  in  1: single clock, same as `game_controller` `clk`.
- `rst`  in  1: asynchronous, active-low reset.
- `player_start`  in  1: synchronous one-cycle request from the debounced start button.
- `gc_state`  in  2: `game_controller` `state` (0 WAITING, 1 COUNTDOWN, 2 SUCCESS, 3 FAILURE).
- `gc_time_remaining`  in  11: `game_controller` `time_remaining`.
- `gc_start`  out  1: to `game_controller` `start`.
- `initial_time`  out  11: to `game_controller`.
- `button_count`  out  6: to `game_controller` / `button_generation`.
- `level`  out  4: current level, 0..15.
- `lives`  out  2: remaining lives.
- `score`  out  16: accumulated score.
- `last_success`  out  1: outcome of the most recent round.
- `seq_state`  out  3: FSM state.
- `game_over`  out  1: high in GAMEOVER.

## Operation
- FSM states and `seq_state` encodings: READY=0, ARM=1, PLAY=2, RESULT=3, CLEAR=4, GAMEOVER=5.
- **READY**: waits for `player_start`, then goes to ARM.
- **ARM**: drives the pulse sequence (`gc_start` high START_HOLD cycles, then low START_HOLD cycles), then goes to PLAY.
- **PLAY** transitions, evaluated on `gc_state`:
  - `gc_state`=2: `score` += `gc_time_remaining` (zero-extended, saturating at 16'hFFFF); `level` += 1 (saturating at 15); `last_success`=1; go to RESULT.
  - `gc_state`=3: `lives` -= 1; `last_success`=0; go to RESULT.
  - `gc_state`=0: external abort of `game_controller`; go to READY with counters unchanged.
  - `gc_state`=1: stay in PLAY.
- **RESULT**: waits for `player_start`, then goes to CLEAR.
- **CLEAR**: drives the same pulse sequence, which returns `game_controller` to WAITING. It then goes to GAMEOVER if `lives`==0, else to READY.
- **GAMEOVER**: `player_start` loads `level`=0, `lives`=MAX_LIVES, `score`=0, `last_success`=0, then goes to READY.
- `player_start` is ignored in ARM, PLAY and CLEAR.
- Config outputs are registered and recomputed the cycle after any `level` change. They are therefore stable before CLEAR, which is when `game_controller` latches them in WAITING.
  - `initial_time` = max(BASE_TIME − level·TIME_STEP, MIN_TIME). The subtraction is computed at 16 bits and a negative result clamps to MIN_TIME.
  - `button_count` = min(BASE_BUTTONS + level, 16).
- Level-up is suppressed if the level is already 15. Score still accrues.

## Timing
- Reset values (asynchronous, immediate):
  - State READY, `gc_start`=0, `level`=0, `lives`=MAX_LIVES, `score`=0, `last_success`=0, `game_over`=0.
  - `initial_time`=BASE_TIME, `button_count`=BASE_BUTTONS.
- Reset mid-pulse drops `gc_start` the same instant.
- All outputs are registered; there are no combinational paths from input to output.
- `player_start` at edge N: `seq_state` changes at N+1, and `gc_start` is high from N+1 through N+START_HOLD.
- START_HOLD ≥ 4 covers the 2-flop synchronizer plus state register in `game_controller`. `gc_state` has therefore left its previous value before PLAY samples it.
- PLAY outcome visible at edge N: counters and `seq_state` update at N+1, and config outputs at N+2.
- A one-cycle pulse counter (width ≥ log2(2·START_HOLD)) clears on entry to ARM/CLEAR.

## Test plan
- Reset, then `player_start` → `gc_start` high for exactly 4 cycles then low for 4; `seq_state` 0→1→2; `initial_time`=600, `button_count`=4.
- In PLAY, drive `gc_state`=2 with `gc_time_remaining`=123 → `score`=123, `level`=1, `last_success`=1; two cycles later `initial_time`=560, `button_count`=5.
- Force `level`=12 via successes → `initial_time`=200 (clamped), `button_count`=16; one more success at level 15 leaves `level`=15 and adds to `score`.
- Three failures, each followed by a RESULT→CLEAR sequence → `lives` 3→2→1→0; after the third CLEAR, `seq_state`=5 and `game_over`=1. Then `player_start` → `lives`=3, `score`=0, `level`=0, back to READY.
- `gc_state`=0 during PLAY → return to READY with `level`, `lives` and `score` unchanged. `player_start` pulses asserted during ARM/PLAY/CLEAR are ignored.
- Assert `rst`=0 in the middle of CLEAR's high phase → `gc_start`=0 immediately and all outputs at their reset values. After release, the FSM resumes from READY.

Source files
------------

// File: rtl/level_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : level_sequencer
// Brief    : Session controller that sequences game_controller through rounds
//            and keeps level, lives and score for a multi-round game.
// Revision : 1.0  initial release
// ============================================================================
module level_sequencer #(
    parameter int BASE_TIME    = 600,
    parameter int TIME_STEP    = 40,
    parameter int MIN_TIME     = 200,
    parameter int BASE_BUTTONS = 4,
    parameter int MAX_LIVES    = 3,
    parameter int START_HOLD   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        player_start,
    input  logic [1:0]  gc_state,
    input  logic [10:0] gc_time_remaining,
    output logic        gc_start,
    output logic [10:0] initial_time,
    output logic [5:0]  button_count,
    output logic [3:0]  level,
    output logic [1:0]  lives,
    output logic [15:0] score,
    output logic        last_success,
    output logic [2:0]  seq_state,
    output logic        game_over
);

    localparam int CNT_W = $clog2(2 * START_HOLD);

    localparam logic [2:0] c_ready    = 3'd0;
    localparam logic [2:0] c_arm      = 3'd1;
    localparam logic [2:0] c_play     = 3'd2;
    localparam logic [2:0] c_result   = 3'd3;
    localparam logic [2:0] c_clear    = 3'd4;
    localparam logic [2:0] c_gameover = 3'd5;

    localparam logic [1:0] c_gc_waiting   = 2'd0;
    localparam logic [1:0] c_gc_countdown = 2'd1;
    localparam logic [1:0] c_gc_success   = 2'd2;
    localparam logic [1:0] c_gc_failure   = 2'd3;

    localparam logic [CNT_W-1:0] c_hold_last  = CNT_W'(START_HOLD - 1);
    localparam logic [CNT_W-1:0] c_pulse_last = CNT_W'(2 * START_HOLD - 1);
    localparam logic [3:0]       c_level_max  = 4'd15;
    localparam logic [5:0]       c_btn_max    = 6'd16;

    logic [CNT_W-1:0] r_pulse_cnt;

    logic [2:0]       w_state_nx;
    logic [CNT_W-1:0] w_cnt_nx;
    logic             w_start_nx;
    logic [3:0]       w_level_nx;
    logic [1:0]       w_lives_nx;
    logic [15:0]      w_score_nx;
    logic             w_last_nx;

    logic [16:0]      w_score_sum;
    logic [15:0]      w_time_diff;
    logic [10:0]      w_time_cfg;
    logic [5:0]       w_btn_sum;
    logic [5:0]       w_btn_cfg;

    // Extra MSB on the sum catches overflow for the saturating score.
    assign w_score_sum = {1'b0, score} + 17'(gc_time_remaining);

    // Difference is treated as signed 16-bit so an underflow also clamps.
    assign w_time_diff = 16'(BASE_TIME) - (16'(level) * 16'(TIME_STEP));
    assign w_time_cfg  = (w_time_diff[15] || (w_time_diff < 16'(MIN_TIME)))
                         ? 11'(MIN_TIME) : 11'(w_time_diff);

    assign w_btn_sum = 6'(BASE_BUTTONS) + {2'b00, level};
    assign w_btn_cfg = (w_btn_sum > c_btn_max) ? c_btn_max : w_btn_sum;

    always_comb begin
        w_state_nx = seq_state;
        w_cnt_nx   = r_pulse_cnt;
        w_start_nx = 1'b0;
        w_level_nx = level;
        w_lives_nx = lives;
        w_score_nx = score;
        w_last_nx  = last_success;

        case (seq_state)
            c_ready: begin
                if (player_start) begin
                    w_state_nx = c_arm;
                    w_cnt_nx   = '0;
                    w_start_nx = 1'b1;
                end
            end

            // ARM and CLEAR share the same high-then-low start pulse.
            c_arm, c_clear: begin
                w_cnt_nx   = r_pulse_cnt + CNT_W'(1);
                w_start_nx = (r_pulse_cnt < c_hold_last);
                if (r_pulse_cnt == c_pulse_last) begin
                    w_cnt_nx = '0;
                    if (seq_state == c_arm) begin
                        w_state_nx = c_play;
                    end else if (lives == 2'd0) begin
                        w_state_nx = c_gameover;
                    end else begin
                        w_state_nx = c_ready;
                    end
                end
            end

            c_play: begin
                case (gc_state)
                    c_gc_success: begin
                        w_score_nx = w_score_sum[16] ? 16'hFFFF : w_score_sum[15:0];
                        w_level_nx = (level == c_level_max) ? level : level + 4'd1;
                        w_last_nx  = 1'b1;
                        w_state_nx = c_result;
                    end
                    c_gc_failure: begin
                        w_lives_nx = (lives == 2'd0) ? lives : lives - 2'd1;
                        w_last_nx  = 1'b0;
                        w_state_nx = c_result;
                    end
                    c_gc_waiting: begin
                        w_state_nx = c_ready;
                    end
                    c_gc_countdown: begin
                        w_state_nx = c_play;
                    end
                    default: begin
                        w_state_nx = c_play;
                    end
                endcase
            end

            c_result: begin
                if (player_start) begin
                    w_state_nx = c_clear;
                    w_cnt_nx   = '0;
                    w_start_nx = 1'b1;
                end
            end

            c_gameover: begin
                if (player_start) begin
                    w_level_nx = 4'd0;
                    w_lives_nx = 2'(MAX_LIVES);
                    w_score_nx = 16'd0;
                    w_last_nx  = 1'b0;
                    w_state_nx = c_ready;
                end
            end

            default: begin
                w_state_nx = c_ready;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seq_state    <= c_ready;
            r_pulse_cnt  <= '0;
            gc_start     <= 1'b0;
            level        <= 4'd0;
            lives        <= 2'(MAX_LIVES);
            score        <= 16'd0;
            last_success <= 1'b0;
            game_over    <= 1'b0;
            initial_time <= 11'(BASE_TIME);
            button_count <= 6'(BASE_BUTTONS);
        end else begin
            seq_state    <= w_state_nx;
            r_pulse_cnt  <= w_cnt_nx;
            gc_start     <= w_start_nx;
            level        <= w_level_nx;
            lives        <= w_lives_nx;
            score        <= w_score_nx;
            last_success <= w_last_nx;
            game_over    <= (w_state_nx == c_gameover);
            // Config follows the registered level, so it lags a level change by one cycle.
            initial_time <= w_time_cfg;
            button_count <= w_btn_cfg;
        end
    end

endmodule
`default_nettype wire
